// File: rtl/router_ctrl_fsm.sv
// ============================================================================
// Module   : router_ctrl_fsm
// Function : Input-side packet sequencing FSM for the 1x3 router. Drives the
//            datapath state strobes, the FIFO write steering and source busy.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module router_ctrl_fsm #(
    parameter logic [1:0] ADDR_INVALID = 2'b11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic [2:0] write_enb,
    output logic       busy
);

    localparam logic [2:0] c_DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] c_LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] c_LOAD_DATA          = 3'd2;
    localparam logic [2:0] c_WAIT_TILL_EMPTY    = 3'd3;
    localparam logic [2:0] c_FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] c_LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] c_LOAD_PARITY        = 3'd6;
    localparam logic [2:0] c_CHECK_PARITY_ERROR = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_addr_q;

    // Padded to four entries so a 2-bit address can index without range issues.
    logic [3:0] w_empty_ext;
    logic [3:0] w_soft_ext;
    logic       w_hdr_ok;
    logic       w_soft_hit;

    assign w_empty_ext = {1'b0, fifo_empty};
    assign w_soft_ext  = {1'b0, soft_reset};
    assign w_hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);
    assign w_soft_hit  = w_soft_ext[r_addr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_DECODE_ADDRESS;
            r_addr_q <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_DECODE_ADDRESS) && w_hdr_ok) begin
                r_addr_q <= data_in;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if ((r_state != c_DECODE_ADDRESS) && w_soft_hit) begin
            w_next_state = c_DECODE_ADDRESS;
        end else begin
            case (r_state)
                c_DECODE_ADDRESS: begin
                    if (w_hdr_ok) begin
                        w_next_state = w_empty_ext[data_in] ? c_LOAD_FIRST_DATA
                                                            : c_WAIT_TILL_EMPTY;
                    end
                end
                c_LOAD_FIRST_DATA: w_next_state = c_LOAD_DATA;
                c_LOAD_DATA: begin
                    // A full FIFO outranks the end of payload.
                    if (fifo_full) begin
                        w_next_state = c_FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        w_next_state = c_LOAD_PARITY;
                    end
                end
                c_FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        w_next_state = c_LOAD_AFTER_FULL;
                    end
                end
                c_LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        w_next_state = c_DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        w_next_state = c_LOAD_PARITY;
                    end else begin
                        w_next_state = c_LOAD_DATA;
                    end
                end
                c_LOAD_PARITY: w_next_state = c_CHECK_PARITY_ERROR;
                c_CHECK_PARITY_ERROR: begin
                    w_next_state = fifo_full ? c_FIFO_FULL_STATE : c_DECODE_ADDRESS;
                end
                c_WAIT_TILL_EMPTY: begin
                    if (w_empty_ext[r_addr_q]) begin
                        w_next_state = c_LOAD_FIRST_DATA;
                    end
                end
                default: w_next_state = c_DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = (r_state == c_DECODE_ADDRESS);
        lfd_state     = (r_state == c_LOAD_FIRST_DATA);
        ld_state      = (r_state == c_LOAD_DATA);
        full_state    = (r_state == c_FIFO_FULL_STATE);
        laf_state     = (r_state == c_LOAD_AFTER_FULL);
        rst_int_reg   = (r_state == c_CHECK_PARITY_ERROR);
        write_enb_reg = (r_state == c_LOAD_FIRST_DATA) || (r_state == c_LOAD_DATA) ||
                        (r_state == c_LOAD_PARITY)     || (r_state == c_LOAD_AFTER_FULL);
        busy          = !((r_state == c_DECODE_ADDRESS) || (r_state == c_LOAD_DATA));
        write_enb     = 3'b000;
        if (write_enb_reg) begin
            case (r_addr_q)
                2'd0:    write_enb = 3'b001;
                2'd1:    write_enb = 3'b010;
                2'd2:    write_enb = 3'b100;
                default: write_enb = 3'b000;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_router_ctrl_fsm.sv
// ============================================================================
// Module   : tb_router_ctrl_fsm
// Function : Directed self-checking bench for router_ctrl_fsm with a
//            phase-level reference model compared every cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_router_ctrl_fsm;

    logic       clock;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [2:0] write_enb;

    int checks = 0;
    int errors = 0;

    router_ctrl_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .write_enb(write_enb), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet phases named after what the router is doing.
    typedef enum {P_IDLE, P_WAIT, P_FIRST, P_PAYLOAD, P_FULL, P_AFTER_FULL,
                  P_PARITY, P_CHECK} phase_t;
    phase_t m_phase;
    int     m_addr;
    bit     m_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase <= P_IDLE;
            m_addr  <= 0;
            m_valid <= 1'b1;
        end else if (m_phase != P_IDLE && soft_reset[m_addr]) begin
            m_phase <= P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: if (pkt_valid && data_in != 2'b11) begin
                    m_addr  <= int'(data_in);
                    m_phase <= fifo_empty[data_in] ? P_FIRST : P_WAIT;
                end
                P_WAIT:       if (fifo_empty[m_addr]) m_phase <= P_FIRST;
                P_FIRST:      m_phase <= P_PAYLOAD;
                P_PAYLOAD:    if (fifo_full) m_phase <= P_FULL;
                              else if (!pkt_valid) m_phase <= P_PARITY;
                P_FULL:       if (!fifo_full) m_phase <= P_AFTER_FULL;
                P_AFTER_FULL: m_phase <= parity_done ? P_IDLE :
                                         (low_pkt_valid ? P_PARITY : P_PAYLOAD);
                P_PARITY:     m_phase <= P_CHECK;
                P_CHECK:      m_phase <= fifo_full ? P_FULL : P_IDLE;
                default:      m_phase <= P_IDLE;
            endcase
        end
    end

    function automatic logic [10:0] model_outputs();
        logic       writing;
        logic [2:0] we;
        writing = (m_phase == P_FIRST) || (m_phase == P_PAYLOAD) ||
                  (m_phase == P_PARITY) || (m_phase == P_AFTER_FULL);
        we = writing ? 3'(1 << m_addr) : 3'b000;
        return {m_phase == P_IDLE, m_phase == P_FIRST, m_phase == P_PAYLOAD,
                m_phase == P_FULL, m_phase == P_AFTER_FULL, m_phase == P_CHECK,
                writing, we, !(m_phase == P_IDLE || m_phase == P_PAYLOAD)};
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            check("cycle_outputs",
                  16'({detect_add, lfd_state, ld_state, full_state, laf_state,
                       rst_int_reg, write_enb_reg, write_enb, busy}),
                  16'(model_outputs()));
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic header(input logic [1:0] a);
        pkt_valid = 1'b1;
        data_in   = a;
        step();
        data_in   = 2'b00;
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        step(2);
        reset = 1'b0;
        check("reset_detect_add", 16'(detect_add), 16'd1);
        check("reset_busy", 16'(busy), 16'd0);
        check("reset_write_enb", 16'(write_enb), 16'd0);

        // Header to FIFO 1: first-data strobe then payload loading.
        header(2'b01);
        check("hdr1_lfd", 16'(lfd_state), 16'd1);
        check("hdr1_write_enb", 16'(write_enb), 16'b010);
        check("hdr1_busy", 16'(busy), 16'd1);
        step();
        check("hdr1_ld", 16'(ld_state), 16'd1);
        check("hdr1_ld_busy", 16'(busy), 16'd0);
        pkt_valid = 1'b0;
        step(3);
        check("hdr1_back_idle", 16'(detect_add), 16'd1);

        // Three payload bytes to FIFO 2, then parity.
        header(2'b10);
        step(3);
        check("p2_ld3", 16'(ld_state), 16'd1);
        pkt_valid = 1'b0;
        step();
        check("p2_parity_we", 16'(write_enb), 16'b100);
        step();
        check("p2_rst_int_reg", 16'(rst_int_reg), 16'd1);
        step();
        check("p2_idle", 16'(detect_add), 16'd1);

        // FIFO 0 not empty: wait, then proceed.
        fifo_empty = 3'b110;
        header(2'b00);
        pkt_valid = 1'b0;
        check("wait_busy", 16'(busy), 16'd1);
        check("wait_we", 16'(write_enb), 16'd0);
        step(2);
        check("wait_hold", 16'({detect_add, lfd_state}), 16'd0);
        fifo_empty = 3'b111;
        step();
        check("wait_to_lfd", 16'(lfd_state), 16'd1);
        pkt_valid = 1'b1;
        step();

        // Full handling with low_pkt_valid release.
        fifo_full = 1'b1;
        step();
        check("full_state", 16'(full_state), 16'd1);
        check("full_we", 16'(write_enb), 16'd0);
        step(4);
        check("full_held5", 16'(full_state), 16'd1);
        fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step();
        check("laf_state", 16'(laf_state), 16'd1);
        step();
        check("laf_to_parity_we", 16'(write_enb), 16'b001);
        low_pkt_valid = 1'b0;
        step(2);

        // Full release with parity already captured.
        header(2'b00);
        step();
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0; parity_done = 1'b1;
        step(2);
        check("laf_parity_done_idle", 16'(detect_add), 16'd1);
        parity_done = 1'b0; pkt_valid = 1'b0;

        // Invalid address is dropped.
        pkt_valid = 1'b1; data_in = 2'b11;
        step(2);
        check("invalid_addr_idle", 16'({detect_add, busy}), 16'b10);
        pkt_valid = 1'b0; data_in = 2'b00;
        step();

        // Soft reset of the selected FIFO aborts; another FIFO's is ignored.
        header(2'b01);
        step();
        fifo_full = 1'b1;
        step();
        soft_reset = 3'b010;
        step();
        check("soft_reset_sel", 16'(detect_add), 16'd1);
        soft_reset = 3'b000; fifo_full = 1'b0;
        header(2'b01);
        step();
        fifo_full = 1'b1;
        step();
        soft_reset = 3'b100;
        step();
        check("soft_reset_other", 16'(full_state), 16'd1);
        soft_reset = 3'b000; fifo_full = 1'b0;
        step(2);
        check("laf_to_ld", 16'(ld_state), 16'd1);

        // Reset mid-packet.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset", 16'({detect_add, lfd_state, ld_state, full_state, laf_state,
                                rst_int_reg, write_enb_reg, write_enb, busy}),
              16'b100_0000_0000);
        pkt_valid = 1'b0;
        step();

        // Full coinciding with end of payload.
        header(2'b10);
        step();
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step();
        check("full_beats_drop", 16'(full_state), 16'd1);
        fifo_full = 1'b0; low_pkt_valid = 1'b1;
        step(2);
        low_pkt_valid = 1'b0;
        step(2);
        check("final_idle", 16'(detect_add), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
- Packet-sequencing controller for the 1x3 router input side.
- Watches the incoming byte stream and the destination FIFO status, then drives the state strobes that control the router register/parity datapath (header latch, data load, full-hold, parity load, internal-register clear).
- Produces the one-hot write enable that steers datapath output into destination FIFO 0, 1 or 2.
- Asserts busy to stall the source.

Parameters:
ADDR_INVALID, 2'b11, address code that is never accepted; DECODE_ADDRESS holds while it is present.

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
pkt_valid  input  1  source byte valid; high for header and payload, low on the parity byte
data_in  input  2  data_in[1:0] of the current byte; the destination address during the header
fifo_full  input  1  full flag of the currently selected FIFO
fifo_empty  input  3  per-FIFO empty flags, bit i = FIFO i
soft_reset  input  3  per-FIFO soft reset (read-side timeout), bit i = FIFO i
parity_done  input  1  datapath has captured the packet parity byte
low_pkt_valid  input  1  datapath has seen pkt_valid drop while loading
detect_add  output  1  state == DECODE_ADDRESS
lfd_state  output  1  state == LOAD_FIRST_DATA
ld_state  output  1  state == LOAD_DATA
full_state  output  1  state == FIFO_FULL_STATE
laf_state  output  1  state == LOAD_AFTER_FULL
rst_int_reg  output  1  state == CHECK_PARITY_ERROR
write_enb_reg  output  1  state in {LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}
write_enb  output  3  write_enb_reg ? one-hot(addr_q) : 3'b000
busy  output  1  high in every state except DECODE_ADDRESS and LOAD_DATA

Behaviour:
- State register is 3-bit, binary encoded.
- All outputs are Moore decodes of the state (and addr_q). There are no combinational input-to-output paths.
- Reset: state=DECODE_ADDRESS and addr_q=2'b00.
  - Resulting outputs: detect_add=1, busy=0, all other strobes 0, write_enb=000.
  - Reset has the highest priority and takes effect in any state, mid-packet included.
- addr_q loads data_in only in DECODE_ADDRESS when pkt_valid=1 and data_in!=ADDR_INVALID. It holds otherwise.
- Soft reset: soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS forces the next state to DECODE_ADDRESS. Priority is below reset and above all transitions. soft_reset bits for non-selected FIFOs are ignored.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid and data_in!=ADDR_INVALID and fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
    - Same but fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY.
    - Else stay; an invalid address is silently dropped.
  - LOAD_FIRST_DATA: -> LOAD_DATA unconditionally (1 cycle).
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - Else !pkt_valid -> LOAD_PARITY.
    - Else stay.
    - fifo_full wins when it coincides with a pkt_valid drop.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - Else low_pkt_valid -> LOAD_PARITY.
    - Else -> LOAD_DATA.
  - LOAD_PARITY: -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
- Latency: header accepted in cycle N (DECODE_ADDRESS) gives lfd_state=1 in cycle N+1 and ld_state=1 in cycle N+2.
- Source is stalled whenever busy=1. The controller does not buffer bytes; the datapath holds the byte that arrived during a full condition.
- Unused state encodings recover to DECODE_ADDRESS on the next clock.

Test Plan:
- Reset then header data_in=2'b01, pkt_valid=1, fifo_empty=3'b111 -> next cycle lfd_state=1, write_enb=3'b010, busy=1; following cycle ld_state=1, busy=0.
- 3-byte payload to FIFO 2, pkt_valid drops on 4th byte -> states LOAD_DATA x3, LOAD_PARITY (write_enb=100), CHECK_PARITY_ERROR (rst_int_reg=1), DECODE_ADDRESS.
- Header to FIFO 0 with fifo_empty=3'b110 -> WAIT_TILL_EMPTY (busy=1, write_enb=000); set fifo_empty[0]=1 -> LOAD_FIRST_DATA the next cycle.
- Full handling:
  - fifo_full=1 in LOAD_DATA -> FIFO_FULL_STATE (full_state=1, write_enb=000) held 5 cycles.
  - Release with low_pkt_valid=1, parity_done=0 -> LOAD_AFTER_FULL then LOAD_PARITY.
  - Repeat with parity_done=1 -> DECODE_ADDRESS.
- Header data_in=2'b11 with pkt_valid=1 -> stays DECODE_ADDRESS, addr_q unchanged, detect_add=1.
- Interrupts and corner cases:
  - soft_reset[1] pulse while in FIFO_FULL_STATE for addr 1 -> DECODE_ADDRESS next cycle.
  - soft_reset[2] in the same situation -> no effect.
  - reset asserted in LOAD_DATA -> DECODE_ADDRESS and all strobes cleared next cycle.
  - fifo_full and !pkt_valid together in LOAD_DATA -> FIFO_FULL_STATE.
